// File: rtl/alarm_ctrl.sv
// alarm_ctrl: compares the BCD wall-clock time with a stored alarm time and
// sequences the alarm through ring, snooze and timeout.
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic       alarm_en,
  input  logic       set_valid,
  input  logic [3:0] hourdec_set,
  input  logic [3:0] hourone_set,
  input  logic [3:0] mindec_set,
  input  logic [3:0] minone_set,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic       snoozing,
  output logic [1:0] snooze_cnt,
  output logic       set_err,
  output logic [3:0] alarm_hd,
  output logic [3:0] alarm_ho,
  output logic [3:0] alarm_md,
  output logic [3:0] alarm_mo
);

  localparam int unsigned SNZ_LEN = SNOOZE_MIN * 60;
  localparam int unsigned RW      = $clog2(RING_SEC + 1);
  localparam int unsigned SW      = $clog2(SNZ_LEN + 1);

  localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_LEN);
  localparam logic [1:0]    MAX_CNT   = 2'(MAX_SNOOZE);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RING   = 2'd1;
  localparam logic [1:0] SNOOZE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [RW-1:0] ring_ctr, ring_ctr_nxt;
  logic [SW-1:0] snz_ctr, snz_ctr_nxt;
  logic [1:0]    cnt_nxt;
  logic          match, match_q, trig, set_ok;

  // Time comparison, edge detection of minute entry, and set-digit validation
  always_comb begin
    match  = (hourdec_now == alarm_hd) && (hourone_now == alarm_ho) &&
             (mindec_now  == alarm_md) && (minone_now  == alarm_mo);
    trig   = match & ~match_q & alarm_en;
    set_ok = (hourdec_set <= 4'd2) && (hourone_set <= 4'd9) &&
             (mindec_set  <= 4'd5) && (minone_set  <= 4'd9) &&
             !((hourdec_set == 4'd2) && (hourone_set > 4'd3));
  end

  // Next-state and counter logic, priority-ordered from disarm downwards
  always_comb begin
    state_nxt    = state;
    ring_ctr_nxt = ring_ctr;
    snz_ctr_nxt  = snz_ctr;
    cnt_nxt      = snooze_cnt;
    if (!alarm_en) begin
      state_nxt = IDLE;
    end else if (set_valid && (state != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state_nxt    = RING;
            ring_ctr_nxt = RING_LOAD;
          end
        end
        RING: begin
          if (stop) begin
            state_nxt = IDLE;
          end else if (snooze && (snooze_cnt < MAX_CNT)) begin
            state_nxt   = SNOOZE;
            snz_ctr_nxt = SNZ_LOAD;
            cnt_nxt     = snooze_cnt + 2'd1;
          end else if (sec_tick) begin
            // An exhausted snooze press falls through here, so the tick still counts
            if (ring_ctr == RW'(1)) state_nxt = IDLE;
            if (ring_ctr != '0)     ring_ctr_nxt = ring_ctr - RW'(1);
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_nxt = IDLE;
          end else if (sec_tick) begin
            if (snz_ctr != '0) snz_ctr_nxt = snz_ctr - SW'(1);
            if (snz_ctr == SW'(1)) begin
              state_nxt    = RING;
              ring_ctr_nxt = RING_LOAD;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if ((state_nxt == IDLE) && (state != IDLE)) cnt_nxt = '0;
  end

  // State, counters, registered output decodes and alarm digit storage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      ring_ctr   <= '0;
      snz_ctr    <= '0;
      snooze_cnt <= '0;
      ring       <= 1'b0;
      snoozing   <= 1'b0;
      set_err    <= 1'b0;
      match_q    <= 1'b1;
      alarm_hd   <= '0;
      alarm_ho   <= '0;
      alarm_md   <= '0;
      alarm_mo   <= '0;
    end else begin
      state      <= state_nxt;
      ring_ctr   <= ring_ctr_nxt;
      snz_ctr    <= snz_ctr_nxt;
      snooze_cnt <= cnt_nxt;
      ring       <= (state_nxt == RING);
      snoozing   <= (state_nxt == SNOOZE);
      set_err    <= set_valid & ~set_ok;
      match_q    <= match;
      if (set_valid && set_ok) begin
        alarm_hd <= hourdec_set;
        alarm_ho <= hourone_set;
        alarm_md <= mindec_set;
        alarm_mo <= minone_set;
      end
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scoreboard bench for alarm_ctrl with sec_tick tied high.
module tb_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rstn, sec_tick, alarm_en, set_valid, snooze, stop;
  logic [15:0] now_t, set_t;
  logic        ring, snoozing, set_err;
  logic [1:0]  snooze_cnt;
  logic [3:0]  alarm_hd, alarm_ho, alarm_md, alarm_mo;

  typedef struct packed {
    logic        ring;
    logic        snz;
    logic [1:0]  cnt;
    logic        err;
    logic [15:0] al;
  } out_t;

  out_t  expq[$];
  string tagq[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_SEC(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .clk(clk), .rstn(rstn), .sec_tick(sec_tick),
    .hourdec_now(now_t[15:12]), .hourone_now(now_t[11:8]),
    .mindec_now(now_t[7:4]), .minone_now(now_t[3:0]),
    .alarm_en(alarm_en), .set_valid(set_valid),
    .hourdec_set(set_t[15:12]), .hourone_set(set_t[11:8]),
    .mindec_set(set_t[7:4]), .minone_set(set_t[3:0]),
    .snooze(snooze), .stop(stop),
    .ring(ring), .snoozing(snoozing), .snooze_cnt(snooze_cnt), .set_err(set_err),
    .alarm_hd(alarm_hd), .alarm_ho(alarm_ho), .alarm_md(alarm_md), .alarm_mo(alarm_mo)
  );

  function automatic out_t ex(input logic r, input logic s, input logic [1:0] c,
                              input logic e, input logic [15:0] a);
    return {r, s, c, e, a};
  endfunction

  task automatic push(input string tag, input out_t e);
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic check_now();
    out_t  e, o;
    string t;
    e = expq.pop_front();
    t = tagq.pop_front();
    o = {ring, snoozing, snooze_cnt, set_err, alarm_hd, alarm_ho, alarm_md, alarm_mo};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic cyc(input string tag, input out_t e);
    push(tag, e);
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic ring_up(input string tag);
    now_t = 16'h0729;
    cyc({tag, "_arm"}, ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    now_t = 16'h0730;
    cyc({tag, "_ring"}, ex(1'b1, 1'b0, 2'd0, 1'b0, 16'h0730));
  endtask

  task automatic snooze_cycle(input logic [1:0] k);
    snooze = 1'b1;
    cyc("snooze_enter", ex(1'b0, 1'b1, k, 1'b0, 16'h0730));
    snooze = 1'b0;
    for (int i = 0; i < 299; i++) cyc("snoozing", ex(1'b0, 1'b1, k, 1'b0, 16'h0730));
    cyc("re_ring", ex(1'b1, 1'b0, k, 1'b0, 16'h0730));
  endtask

  initial begin
    rstn = 1'b1; sec_tick = 1'b1; alarm_en = 1'b0; set_valid = 1'b0;
    snooze = 1'b0; stop = 1'b0; now_t = 16'h0000; set_t = 16'h0000;
    #2 rstn = 1'b0;
    #2;
    push("reset", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000));
    check_now();
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc("idle_after_rst", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000));

    // 1: set 07:30, minute entry triggers, 60-tick timeout, no retrigger
    alarm_en = 1'b1; now_t = 16'h0729; set_t = 16'h0730; set_valid = 1'b1;
    cyc("set_0730", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    set_valid = 1'b0;
    cyc("pre_match", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    now_t = 16'h0730;
    cyc("ring_on", ex(1'b1, 1'b0, 2'd0, 1'b0, 16'h0730));
    for (int i = 0; i < 59; i++) cyc("ringing", ex(1'b1, 1'b0, 2'd0, 1'b0, 16'h0730));
    cyc("ring_timeout", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    for (int i = 0; i < 3; i++) cyc("no_retrig", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));

    // 2: invalid sets pulse set_err and leave the digits alone; 23:59 is legal
    set_t = 16'h2400; set_valid = 1'b1;
    cyc("err_2400", ex(1'b0, 1'b0, 2'd0, 1'b1, 16'h0730));
    set_valid = 1'b0;
    cyc("err_2400_clr", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    set_t = 16'h1260; set_valid = 1'b1;
    cyc("err_1260", ex(1'b0, 1'b0, 2'd0, 1'b1, 16'h0730));
    set_valid = 1'b0;
    cyc("err_1260_clr", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    now_t = 16'h0800; set_t = 16'h2359; set_valid = 1'b1;
    cyc("set_2359", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h2359));
    set_t = 16'h0730;
    cyc("set_back_0730", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    set_valid = 1'b0;

    // 3: three snoozes, fourth is ignored, stop clears the count
    ring_up("t3");
    snooze_cycle(2'd1);
    snooze_cycle(2'd2);
    snooze_cycle(2'd3);
    snooze = 1'b1;
    cyc("snooze_4th", ex(1'b1, 1'b0, 2'd3, 1'b0, 16'h0730));
    snooze = 1'b0; stop = 1'b1;
    cyc("stop_after_max", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    stop = 1'b0;

    // 4: stop wins over simultaneous snooze
    ring_up("t4");
    snooze_cycle(2'd1);
    stop = 1'b1; snooze = 1'b1;
    cyc("stop_snooze", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    stop = 1'b0; snooze = 1'b0;

    // set_valid while ringing returns to idle even when rejected
    ring_up("tset");
    set_t = 16'h9999; set_valid = 1'b1;
    cyc("set_in_ring", ex(1'b0, 1'b0, 2'd0, 1'b1, 16'h0730));
    set_valid = 1'b0;
    cyc("set_in_ring_clr", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));

    // 5: disarm mid-snooze, nothing rings afterwards
    ring_up("t5");
    snooze = 1'b1;
    cyc("t5_snooze", ex(1'b0, 1'b1, 2'd1, 1'b0, 16'h0730));
    snooze = 1'b0;
    for (int i = 0; i < 5; i++) cyc("t5_snoozing", ex(1'b0, 1'b1, 2'd1, 1'b0, 16'h0730));
    alarm_en = 1'b0;
    cyc("en_off", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));
    alarm_en = 1'b1;
    for (int i = 0; i < 305; i++) cyc("no_ring_after_off", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0730));

    // 6: async reset mid-ring, then release on a matching 00:00
    ring_up("t6");
    for (int i = 0; i < 3; i++) cyc("t6_ringing", ex(1'b1, 1'b0, 2'd0, 1'b0, 16'h0730));
    #2 rstn = 1'b0;
    #1;
    push("async_reset", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000));
    check_now();
    now_t = 16'h0000; alarm_en = 1'b1;
    #3 rstn = 1'b1;
    for (int i = 0; i < 5; i++) cyc("post_rst_no_ring", ex(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
